// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic ADD/ANDC requests into 16-bit IReg words and
// queues them in a small FIFO for the decoder; undecodable requests pulse ERR.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic                    OPCLASS,
    input  logic [1:0]              MODE,
    input  logic [2:0]              RN,
    input  logic [2:0]              RI,
    input  logic [7:0]              DATA,
    input  logic [6:0]              ADDRESS,
    output logic [15:0]             IReg,
    output logic                    IREG_VALID,
    input  logic                    IREG_READY,
    output logic                    ERR,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic [15:0]             ISSUED
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          r_err;
    logic [15:0]   r_issued;
    logic          w_accept;
    logic          w_reject;
    logic          w_push;
    logic          w_pop;
    logic [15:0]   w_word;
    // Direct addresses 0x10-0x17 share the @Ri bit pattern, so they cannot be issued.
    always_comb begin
        w_accept = IN_VALID & IN_READY;
        w_reject = (MODE == 2'd3) | (OPCLASS & (MODE != 2'd0))
                 | ((MODE == 2'd1) & (ADDRESS[6:3] == 4'b0010));
        w_push   = w_accept & ~w_reject;
        w_pop    = IREG_VALID & IREG_READY;
        w_word   = (MODE == 2'd0) ? {3'b000, OPCLASS, 1'b1, RN, DATA}
                 : (MODE == 2'd1) ? {5'b00000, RN, 1'b0, ADDRESS}
                 :                  {5'b00000, RN, 5'b00010, RI};
    end
    assign IN_READY   = (r_count != CW'(DEPTH));
    assign IREG_VALID = (r_count != '0);
    assign IReg       = r_mem[r_rp];
    assign ERR        = r_err;
    assign COUNT      = r_count;
    assign ISSUED     = r_issued;
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_issued <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= w_word;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp     <= r_rp + AW'(1);
                r_issued <= r_issued + 16'd1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_err   <= w_accept & w_reject;
        end
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Issue-side counterpart of the instruction decoder. It accepts symbolic instruction fields (operation, addressing mode, registers, immediate or address) over a valid/ready handshake. Each accepted request is packed into the 16-bit IReg format the decoder consumes, and the word is buffered in a small FIFO. Words are presented to the decoder side on a second valid/ready handshake. Requests that the decoder cannot distinguish or does not support are rejected and flagged.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  encoder can accept; equals !full.
- OPCLASS  in  1  0 = ADD, 1 = ANDC.
- MODE  in  2  0 = #data, 1 = direct address, 2 = @Ri, 3 = illegal.
- RN  in  3  destination register.
- RI  in  3  indirect register (MODE 2 only).
- DATA  in  8  immediate (MODE 0 only).
- ADDRESS  in  7  direct address (MODE 1 only).
- IReg  out  16  FIFO head word.
- IREG_VALID  out  1  FIFO non-empty.
- IREG_READY  in  1  consumer takes head.
- ERR  out  1  one-cycle pulse, cycle after a rejected request.
- COUNT  out  $clog2(DEPTH)+1  current occupancy.
- ISSUED  out  16  words popped since reset; wraps at 0xFFFF→0x0000.

## Operation
- Accept = IN_VALID & IN_READY. Pop = IREG_VALID & IREG_READY.
- Encoding (bit 15 MSB):
  - ADD #data: {4'b0000, 1'b1, RN, DATA}.
  - ADD direct: {4'b0000, 1'b0, RN, 1'b0, ADDRESS}.
  - ADD @Ri: {4'b0000, 1'b0, RN, 5'b00010, RI}.
  - ANDC #data: {4'b0001, 1'b1, RN, DATA}.
- Rejection: an accepted request is consumed (handshake completes), is not written to the FIFO, and raises ERR the next cycle. It is rejected if any of the following holds:
  - MODE == 3.
  - OPCLASS == 1 with MODE != 0.
  - MODE == 1 with ADDRESS[6:3] == 4'b0010. These addresses 0x10–0x17 would alias the @Ri pattern.
- Unused input fields are ignored. Example: DATA in MODE 1 does not affect the word.
- FIFO:
  - Registered storage with write and read pointers. Pointers wrap modulo DEPTH.
  - COUNT tracks occupancy 0..DEPTH.
  - Occupancy updates per cycle:
    - Valid push only: COUNT +1.
    - Pop only: COUNT −1.
    - Valid push and pop together: COUNT unchanged, both pointers advance.
    - Rejected accept with a pop: behaves as pop only.
- Full: IN_READY = 0, even when a pop occurs in the same cycle. There is no bypass of full.
- Empty: IREG_VALID = 0. IReg holds the last head value and is don't-care. A pop cannot occur.
- ISSUED increments by 1 on every pop.

## Timing
- Reset values (asserted for ≥1 cycle):
  - COUNT = 0, IREG_VALID = 0, IN_READY = 1, ERR = 0, ISSUED = 0, pointers = 0, IReg = 0x0000.
- Reset mid-operation: all buffered words are discarded. A request presented during reset is not accepted.
- Latency: a word accepted in cycle N into an empty FIFO appears on IReg with IREG_VALID = 1 in cycle N+1.
- IReg and IREG_VALID are stable while IREG_VALID = 1 and IREG_READY = 0.
- The next head is visible in the cycle after a pop.
- ERR rises in cycle N+1 for a rejection accepted in cycle N and lasts exactly one cycle. Back-to-back rejections give back-to-back pulses.
- IN_READY depends only on registered COUNT. There is no combinational path from IREG_READY to IN_READY.

## Test plan
- After reset, ADD R3,#0x5A (OPCLASS 0, MODE 0, RN 3, DATA 0x5A) -> next cycle IReg = 0x0B5A, IREG_VALID = 1, COUNT = 1.
- Push ADD R2,0x45 (MODE 1), then ADD R5,@R6 (MODE 2), then ANDC R1,#0xFF, with IREG_READY = 0; then hold IREG_READY = 1 -> pops in order 0x0245, 0x0516, 0x19FF; ISSUED = 3; COUNT returns to 0.
- ADD R0, direct 0x12; ANDC with MODE 1; MODE 3 -> three ERR pulses; COUNT stays 0; IREG_VALID stays 0.
- Fill 4 entries with IREG_READY = 0 -> IN_READY = 0 at COUNT = 4. Then hold IN_VALID = 1 with IREG_READY = 1 -> IN_READY stays 0 in the pop cycle, returns to 1 the next cycle; order preserved across pointer wrap.
- Steady stream with IN_VALID = IREG_READY = 1 at COUNT = 2 -> COUNT stays 2 every cycle; output words match inputs two deep.
- Reset asserted with COUNT = 3 -> next cycle COUNT = 0, IREG_VALID = 0, ISSUED = 0. Preload ISSUED by popping 0x10000 words -> ISSUED wraps 0xFFFF→0x0000.
